reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb.sv | 68 ++++++
 tb/tb_reg_file_sb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: flat GPR/SP/IH/T register file with write bypass and a per-register
// busy scoreboard for RAW hazard detection in decode.
module reg_file_sb #(
   parameter int                 DATA_W  = 16,
   parameter int                 GPR_N   = 8,
   parameter int                 ADDR_W  = 4,
   parameter logic [DATA_W-1:0]  SP_INIT = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush
);
   localparam int REG_N = GPR_N + 3;
   // one extra bit so REG_N == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(REG_N);

   logic [DATA_W-1:0] r_regs [REG_N];
   logic [REG_N-1:0]  r_busy;
   logic [REG_N-1:0]  w_busy_nxt;
   logic              w_wr_map;
   logic [ADDR_W-1:0] w_ra [2];
   logic [DATA_W-1:0] w_rd [2];
   logic [1:0]        w_rb;

   assign w_wr_map = {1'b0, wr_addr} < NREG;
   assign w_ra[0]  = rd_addr1;
   assign w_ra[1]  = rd_addr2;
   assign rd_data1 = w_rd[0];
   assign rd_data2 = w_rd[1];
   assign rd_busy1 = w_rb[0];
   assign rd_busy2 = w_rb[1];

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic w_map, w_hit;
      assign w_map   = {1'b0, w_ra[p]} < NREG;
      assign w_hit   = w_map && wr_en && (wr_addr == w_ra[p]);
      assign w_rd[p] = !w_map ? '0 : w_hit ? wr_data : r_regs[w_ra[p]];
      assign w_rb[p] = w_map && r_busy[w_ra[p]] && !w_hit;
   end

   // a new issue outranks flush, which outranks the clearing writeback
   for (genvar r = 0; r < REG_N; r++) begin : g_busy
      assign w_busy_nxt[r] = (iss_en && iss_addr == ADDR_W'(r)) ? 1'b1 :
                             flush                              ? 1'b0 :
                             (wr_en && wr_addr == ADDR_W'(r))   ? 1'b0 : r_busy[r];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < REG_N; i++) r_regs[i] <= (i == GPR_N) ? SP_INIT : '0;
         r_busy <= '0;
      end else begin
         if (wr_en && w_wr_map) r_regs[wr_addr] <= wr_data;
         r_busy <= w_busy_nxt;
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against an
// array-based reference model of registers and outstanding producers.
module tb_reg_file_sb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, iss_en, flush;
   logic [3:0]  wr_addr, rd_addr1, rd_addr2, iss_addr;
   logic [15:0] wr_data, rd_data1, rd_data2;
   logic        rd_busy1, rd_busy2;
   logic [15:0] regs_m [11];
   bit          busy_m [11];
   int          n_pass = 0, n_total = 0;

   reg_file_sb #(.DATA_W(16), .GPR_N(8), .ADDR_W(4), .SP_INIT(16'hBF00)) dut (
      .CLK(clk), .RST_N(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .iss_en(iss_en), .iss_addr(iss_addr),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic void model_reset();
      foreach (regs_m[i]) begin regs_m[i] = 16'h0; busy_m[i] = 1'b0; end
      regs_m[8] = 16'hBF00;
   endfunction

   function automatic logic [15:0] exp_data(input logic [3:0] a);
      if (a > 10) return 16'h0;
      if (wr_en && wr_addr == a) return wr_data;
      return regs_m[a];
   endfunction

   function automatic logic exp_busy(input logic [3:0] a);
      if (a > 10) return 1'b0;
      return busy_m[a] && !(wr_en && wr_addr == a);
   endfunction

   task automatic chk_ports(input string tag);
      #1;
      chk({tag, "_d1"}, 32'(rd_data1), 32'(exp_data(rd_addr1)));
      chk({tag, "_d2"}, 32'(rd_data2), 32'(exp_data(rd_addr2)));
      chk({tag, "_b1"}, 32'(rd_busy1), 32'(exp_busy(rd_addr1)));
      chk({tag, "_b2"}, 32'(rd_busy2), 32'(exp_busy(rd_addr2)));
   endtask

   // model applies the clock-edge rules, then we return to the falling edge to drive
   task automatic tick();
      @(posedge clk);
      if (wr_en && wr_addr <= 10) regs_m[wr_addr] = wr_data;
      if (flush) foreach (busy_m[i]) busy_m[i] = 1'b0;
      else if (wr_en && wr_addr <= 10) busy_m[wr_addr] = 1'b0;
      if (iss_en && iss_addr <= 10) busy_m[iss_addr] = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 0; iss_en = 0; flush = 0; wr_addr = 0; wr_data = 0; iss_addr = 0;
   endtask

   initial begin
      rst_n = 1'b0; idle(); rd_addr1 = 0; rd_addr2 = 0;
      model_reset();
      @(negedge clk);
      for (int a = 0; a < 11; a++) begin
         rd_addr1 = 4'(a); rd_addr2 = 4'(10 - a);
         chk_ports("reset");
      end
      rd_addr1 = 8; #1;
      chk("reset_sp", 32'(rd_data1), 32'h0000_BF00);
      rst_n = 1'b1;
      @(negedge clk);

      wr_en = 1; wr_addr = 3; wr_data = 16'h1234; rd_addr1 = 3; rd_addr2 = 3;
      chk_ports("bypass");
      chk("bypass_const", 32'(rd_data1), 32'h1234);
      tick(); idle();
      chk_ports("stored");
      chk("stored_const", 32'(rd_data1), 32'h1234);

      wr_en = 1; wr_addr = 9; wr_data = 16'hA5A5; tick();
      wr_addr = 10; wr_data = 16'h0001; tick();
      wr_addr = 15; wr_data = 16'hDEAD; rd_addr1 = 15; rd_addr2 = 15;
      chk_ports("unmapped_bypass");
      tick(); idle();
      rd_addr2 = 9; chk_ports("ih");
      chk("ih_const", 32'(rd_data2), 32'hA5A5);
      rd_addr2 = 10; chk_ports("t");
      chk("t_const", 32'(rd_data2), 32'h0001);
      chk("unmapped_const", 32'(rd_data1), 32'h0);

      iss_en = 1; iss_addr = 5; rd_addr1 = 5; tick(); idle();
      chk_ports("issued");
      chk("issued_const", 32'(rd_busy1), 32'h1);
      wr_en = 1; wr_addr = 5; wr_data = 16'h5555;
      chk_ports("wb_mask");
      chk("wb_mask_const", 32'(rd_busy1), 32'h0);
      tick(); idle();
      chk_ports("wb_done");
      chk("wb_done_const", 32'(rd_busy1), 32'h0);

      iss_en = 1; iss_addr = 2; tick();
      iss_addr = 6; tick();
      wr_en = 1; wr_addr = 2; wr_data = 16'h2222; iss_en = 1; iss_addr = 2; flush = 1;
      tick(); idle();
      rd_addr1 = 2; rd_addr2 = 6; chk_ports("prio");
      chk("prio_b2", 32'(rd_busy1), 32'h1);
      chk("prio_b6", 32'(rd_busy2), 32'h0);

      for (int n = 0; n < 400; n++) begin
         wr_en    = ($urandom_range(0, 2) != 0);
         wr_addr  = 4'($urandom_range(0, 15));
         wr_data  = 16'($urandom);
         iss_en   = ($urandom_range(0, 2) == 0);
         iss_addr = 4'($urandom_range(0, 15));
         flush    = ($urandom_range(0, 15) == 0);
         rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         rd_addr2 = ($urandom_range(0, 5) == 0) ? rd_addr1 : 4'($urandom_range(0, 15));
         chk_ports("rand");
         tick();
      end

      idle();
      wr_en = 1; wr_addr = 1; wr_data = 16'hFFFF; iss_en = 1; iss_addr = 4; tick(); idle();
      rd_addr1 = 1; rd_addr2 = 4;
      chk_ports("pre_areset");
      #2 rst_n = 1'b0; model_reset();
      chk_ports("areset");
      chk("areset_r1", 32'(rd_data1), 32'h0);
      chk("areset_b4", 32'(rd_busy2), 32'h0);
      #1 rst_n = 1'b1;
      tick();
      chk_ports("post_areset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
